wci_master_ctl: RTL

WCI_MASTER_CTL -- requirements
Module: wci_master_ctl

---
 rtl/wci_master_ctl_if.sv | 38 +++
 rtl/wci_master_ctl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wci_master_ctl_if.sv
// WCI slave-channel signal bundle.
//
// The master modport is the side that issues commands (wci_master_ctl).
// The slave modport is the side that answers them (a WCI worker or a bench model).
//
// Signals:
//   wci_MCmd        master->slave  command: 0=IDLE, 1=WR, 2=RD
//   wci_MAddrSpace  master->slave  0=control space, 1=config space
//   wci_MByteEn     master->slave  byte enables
//   wci_MAddr       master->slave  byte address
//   wci_MData       master->slave  write data
//   wci_MFlag       master->slave  sideband flags from the host
//   wci_SResp       slave->master  response: 0=NULL, 1=DVA, 2=FAIL, 3=ERR
//   wci_SData       slave->master  read data
//   wci_SThreadBusy slave->master  1 = slave cannot take a command this edge
//   wci_SFlag       slave->master  [0]=attention, [1]=present
interface wci_master_ctl_if;
  logic [2:0]  wci_MCmd;
  logic        wci_MAddrSpace;
  logic [3:0]  wci_MByteEn;
  logic [31:0] wci_MAddr;
  logic [31:0] wci_MData;
  logic [1:0]  wci_MFlag;
  logic [1:0]  wci_SResp;
  logic [31:0] wci_SData;
  logic        wci_SThreadBusy;
  logic [1:0]  wci_SFlag;

  modport master (
    output wci_MCmd, wci_MAddrSpace, wci_MByteEn, wci_MAddr, wci_MData, wci_MFlag,
    input  wci_SResp, wci_SData, wci_SThreadBusy, wci_SFlag
  );

  modport slave (
    input  wci_MCmd, wci_MAddrSpace, wci_MByteEn, wci_MAddr, wci_MData, wci_MFlag,
    output wci_SResp, wci_SData, wci_SThreadBusy, wci_SFlag
  );
endinterface

// File: rtl/wci_master_ctl.sv
// WCI master control-channel bridge.
//
// This module takes one host request at a time and turns it into a single
// WCI command. It waits for the slave's response and returns it to the host
// as a one-cycle strobe. At most one transaction is outstanding.
//
// Optional feature macro: WCI_MASTER_TIMEOUT_EN
//   When defined, a transaction that gets no SResp within TIMEOUT_CYC cycles
//   of ISSUE+WAIT completes with rsp_code=3.
//   When undefined, there is no counter and the block waits indefinitely.
//
// Parameters:
//   TIMEOUT_CYC  cycles allowed from command issue to SResp (2..65535)
//
// Ports:
//   CLK, RST_N           clock; asynchronous active-low reset
//   req_valid/req_ready  host request handshake
//   req_write, req_space, req_addr, req_be, req_data   request fields
//   rsp_valid            one-cycle response strobe
//   rsp_data, rsp_code   response payload (code: 0=ok, 1=FAIL, 2=ERR, 3=timeout)
//   host_mflag           forwarded (registered) to wci_MFlag
//   attention, present   registered copies of wci_SFlag[0] / wci_SFlag[1]
//   dbg_state            current FSM state (0=IDLE, 1=ISSUE, 2=WAIT, 3=RESP)
//   wci                  master end of the WCI slave channel
//
// Handshake semantics:
//   A host request transfers on a rising edge where req_valid=1 and req_ready=1.
//   A WCI command transfers on a rising edge in ISSUE where wci_SThreadBusy=0.
//   rsp_valid is a strobe with no back-pressure.
//   The minimum request-to-response path is four cycles: the handshake cycle,
//   then ISSUE, WAIT and RESP, with rsp_valid high in RESP.
module wci_master_ctl #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic               req_space,
  input  logic [31:0]        req_addr,
  input  logic [3:0]         req_be,
  input  logic [31:0]        req_data,
  output logic               rsp_valid,
  output logic [31:0]        rsp_data,
  output logic [1:0]         rsp_code,
  input  logic [1:0]         host_mflag,
  output logic               attention,
  output logic               present,
  output logic [1:0]         dbg_state,
  wci_master_ctl_if.master   wci
);

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;

  localparam logic [1:0] SRESP_NULL  = 2'd0;
  localparam logic [1:0] RSP_TIMEOUT = 2'd3;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("wci_master_ctl: TIMEOUT_CYC must be in 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state;
  logic   wr_q;  // transaction direction; writes return zero data

`ifdef WCI_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_cnt;  // cycles spent in ISSUE+WAIT, starting from 0
`endif

  assign dbg_state = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state              <= S_IDLE;
      req_ready          <= 1'b0;
      wr_q               <= 1'b0;
      wci.wci_MCmd       <= CMD_IDLE;
      wci.wci_MAddrSpace <= 1'b0;
      wci.wci_MByteEn    <= '0;
      wci.wci_MAddr      <= '0;
      wci.wci_MData      <= '0;
      wci.wci_MFlag      <= '0;
      rsp_valid          <= 1'b0;
      rsp_data           <= '0;
      rsp_code           <= '0;
      attention          <= 1'b0;
      present            <= 1'b0;
`ifdef WCI_MASTER_TIMEOUT_EN
      tmo_cnt            <= '0;
`endif
    end else begin
      // Sideband flags pass through with one register stage in every state.
      wci.wci_MFlag <= host_mflag;
      attention     <= wci.wci_SFlag[0];
      present       <= wci.wci_SFlag[1];

      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            // Request fields go straight into the bus registers. They appear
            // together with MCmd and then hold until the next request.
            wr_q               <= req_write;
            wci.wci_MCmd       <= req_write ? CMD_WR : CMD_RD;
            wci.wci_MAddrSpace <= req_space;
            wci.wci_MByteEn    <= req_be;
            wci.wci_MAddr      <= req_addr;
            wci.wci_MData      <= req_data;
            req_ready          <= 1'b0;
            state              <= S_ISSUE;
`ifdef WCI_MASTER_TIMEOUT_EN
            tmo_cnt            <= '0;
`endif
          end
        end

        S_ISSUE: begin
`ifdef WCI_MASTER_TIMEOUT_EN
          if (tmo_cnt == TMO_LAST) begin
            wci.wci_MCmd <= CMD_IDLE;
            rsp_code     <= RSP_TIMEOUT;
            rsp_data     <= '0;
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (!wci.wci_SThreadBusy) begin
              wci.wci_MCmd <= CMD_IDLE;
              state        <= S_WAIT;
            end
          end
`else
          if (!wci.wci_SThreadBusy) begin
            wci.wci_MCmd <= CMD_IDLE;
            state        <= S_WAIT;
          end
`endif
        end

        S_WAIT: begin
          // A real response wins over a timeout that fires on the same edge.
          if (wci.wci_SResp != SRESP_NULL) begin
            rsp_code  <= wci.wci_SResp - 2'd1;
            rsp_data  <= wr_q ? 32'd0 : wci.wci_SData;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
`ifdef WCI_MASTER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            rsp_code  <= RSP_TIMEOUT;
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end

        S_RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
